// File: rtl/sum_serial_addsub.sv
// Chunk-serial N-bit adder/subtractor: W bits per accepted cycle, LSB chunk first, carry kept across chunks.
// Define SUM_SERIAL_OVERFLOW_EN to add the ovf output (signed overflow on the final chunk).
module sum_serial_addsub #(
  parameter int N = 128,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         mode_sub,
  input  logic         in_valid,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] c,
  output logic         out_valid,
  output logic         last,
  output logic         carry_out
`ifdef SUM_SERIAL_OVERFLOW_EN
  ,
  output logic         ovf
`endif
);

  localparam int CC    = N / W;
  localparam int CNT_W = $clog2(CC);

  function automatic logic [W:0] add_chunk(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
  endfunction

  logic [CNT_W-1:0] cnt;
  logic             carry_q;
  logic             mode_q;

  logic             first;
  logic             is_last;
  logic             sub_eff;
  logic             cin;
  logic [W-1:0]     b_eff;
  logic [W:0]       total;
  logic             cin_msb;

  // Chunk 0 takes its mode and carry-in straight from mode_sub; later chunks use the latched state.
  assign first   = (cnt == '0);
  assign is_last = (cnt == CNT_W'(CC - 1));
  assign sub_eff = first ? mode_sub : mode_q;
  assign cin     = first ? mode_sub : carry_q;
  assign b_eff   = sub_eff ? ~b : b;
  assign total   = add_chunk(a, b_eff, cin);
  assign cin_msb = a[W-1] ^ b_eff[W-1] ^ total[W-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      carry_q   <= 1'b0;
      mode_q    <= 1'b0;
      c         <= '0;
      out_valid <= 1'b0;
      last      <= 1'b0;
      carry_out <= 1'b0;
`ifdef SUM_SERIAL_OVERFLOW_EN
      ovf       <= 1'b0;
`endif
    end else if (clr) begin
      cnt       <= '0;
      carry_q   <= 1'b0;
      mode_q    <= 1'b0;
      out_valid <= 1'b0;
      last      <= 1'b0;
      carry_out <= 1'b0;
`ifdef SUM_SERIAL_OVERFLOW_EN
      ovf       <= 1'b0;
`endif
    end else if (in_valid) begin
      c         <= total[W-1:0];
      out_valid <= 1'b1;
      if (first) mode_q <= mode_sub;
      if (is_last) begin
        cnt       <= '0;
        carry_q   <= 1'b0;
        last      <= 1'b1;
        carry_out <= total[W];
`ifdef SUM_SERIAL_OVERFLOW_EN
        ovf       <= cin_msb ^ total[W];
`endif
      end else begin
        cnt       <= cnt + 1'b1;
        carry_q   <= total[W];
        last      <= 1'b0;
        carry_out <= 1'b0;
`ifdef SUM_SERIAL_OVERFLOW_EN
        ovf       <= 1'b0;
`endif
      end
    end else begin
      out_valid <= 1'b0;
      last      <= 1'b0;
      carry_out <= 1'b0;
`ifdef SUM_SERIAL_OVERFLOW_EN
      ovf       <= 1'b0;
`endif
    end
  end

`ifndef SUM_SERIAL_OVERFLOW_EN
  logic unused_msb;
  assign unused_msb = cin_msb;
`endif

endmodule

// File: doc/sum_serial_addsub.md
Name: sum_serial_addsub

Overview:
- Parametrised successor to the fixed 128-bit, 32-cycle serial adder used in the garbled-circuit netlist set.
- Adds or subtracts two N-bit operands presented LSB-chunk-first, W bits per cycle, over N/W cycles.
- Keeps the carry or borrow across chunks and adds per-chunk valid/stall, an operation-boundary flag, an abort, and a carry-out report.
- Sits between operand chunk sources and the result sink in the arithmetic datapath.

Parameters:
- N, 128, total operand width in bits; must satisfy N % W == 0 and N/W >= 2.
- W, 4, chunk width in bits processed per accepted cycle.
- (derived, local) CC = N/W chunks per operation; CNT_W = $clog2(CC).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous abort of the operation in progress.
- mode_sub  in  1  0 = a+b, 1 = a-b; sampled only on chunk 0.
- in_valid  in  1  a/b chunk is valid this cycle.
- a  in  W  operand A chunk, LSB chunk first.
- b  in  W  operand B chunk, LSB chunk first.
- c  out  W  registered result chunk.
- out_valid  out  1  c holds a new chunk.
- last  out  1  c is the final (MSB) chunk of an operation.
- carry_out  out  1  final carry (add) or no-borrow (sub); meaningful when last=1, 0 otherwise.

Behaviour:
- Reset (rst=0, asynchronous): c=0, out_valid=0, last=0, carry_out=0, chunk counter=0, carry register=0, mode register=0. Outputs stay at these values until the first accepted chunk after rst returns to 1.
- Chunk acceptance: a chunk is accepted when in_valid=1 and clr=0. When in_valid=0, counter, carry and mode hold, and out_valid=0 on the next cycle. The stall length is unbounded.
- Chunk 0 (counter==0):
  - mode_sub is latched into the mode register.
  - Carry-in = mode_sub.
  - Operand B = mode_sub ? ~b : b.
- Chunks 1..CC-1:
  - Carry-in = carry register.
  - B inversion uses the latched mode; mode_sub is ignored.
- Each accepted chunk computes {cout, sum} = a + B' + cin, which is W+1 bits wide.
- Register updates on each accepted chunk:
  - c <= sum
  - carry register <= cout
  - out_valid <= 1
  - latency is exactly 1 cycle from acceptance to out_valid.
- Counter increments per accepted chunk and wraps from CC-1 to 0. Back-to-back operations need no idle cycle.
- On the accepted chunk with counter==CC-1:
  - last <= 1
  - carry_out <= cout
  - carry register is cleared to 0
- last and carry_out are 0 on every other cycle.
- clr=1: counter, carry and mode registers go to 0, and out_valid, last and carry_out go to 0 next cycle. c holds its value. A chunk presented in the same cycle is dropped, so clr wins over in_valid.
- Reset mid-operation discards the partial operation. The next accepted chunk is treated as chunk 0.
- There is no back-pressure on the output. The sink must take every out_valid cycle.

Optional Feature:
- Macro: SUM_SERIAL_OVERFLOW_EN.
- When defined:
  - Adds output port ovf (out, 1).
  - On the final chunk, ovf <= cin_msb XOR cout, where cin_msb is the carry into bit W-1 of that chunk. This is signed two's-complement overflow for the selected mode.
  - ovf is 0 on all other cycles, on reset and after clr.
- When undefined: port and logic are absent, and all other behaviour is identical.

Test Plan (N=16, W=4, CC=4):
- Add 0x1234+0x0FCD, chunks a=4,3,2,1 and b=D,C,F,0, in_valid held high -> c=1,0,2,2 on consecutive cycles; last only on the 4th; carry_out=0.
- Add 0xFFFF+0x0001 -> c=0,0,0,0; last=1 with carry_out=1. Start a second op 0x0001+0x0001 immediately, with no gap -> c=2,0,0,0 and carry_out=0, confirming the carry is cleared.
- Sub 0x0005-0x0007, mode_sub=1 on chunk 0 only, then toggle mode_sub on chunks 1-3 -> c=E,F,F,F (0xFFFE); carry_out=0 (borrow).
- Add 0x1234+0x0FCD with in_valid deasserted for 3 cycles between chunks 1 and 2 -> out_valid=0 during the stall; final result 0x2201 unchanged.
- Abort: after 2 chunks of 0xFFFF+0x0001, assert clr together with in_valid -> that chunk is dropped, out_valid=0 next cycle. Then 0x0003+0x0004 -> c=7,0,0,0 with last on the 4th chunk. Repeat the sequence with an rst=0 pulse in place of clr -> all outputs 0 immediately, same recovery.
- With SUM_SERIAL_OVERFLOW_EN defined:
  - 0x7FFF+0x0001 -> c=0,0,0,8; ovf=1; carry_out=0.
  - 0x8000-0x0001 -> c=F,F,F,7 (0x7FFF); ovf=1.
  - 0x1234+0x0FCD -> ovf=0.
